// File: rtl/conv_sequencer.sv
// conv_sequencer: serial NxN (N=2..5) convolution, one MAC per clock, valid/ready result.
// Optional macro CONV_SATURATE_EN: 21-bit accumulator with clamp to 16-bit signed range.
`default_nettype none

module conv_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            matrix_size,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [199:0]          result_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef CONV_SATURATE_EN
  localparam int ACC_W = 21;
`else
  localparam int ACC_W = RESULT_WIDTH;
`endif

  state_t                   state_q, state_d;
  logic [1:0]               size_q, size_d;
  logic [2:0]               row_q, row_d;
  logic [2:0]               col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [RESULT_WIDTH-1:0]  res_q, res_d;
  logic                     valid_q, valid_d;
  logic                     wr_err_q, wr_err_d;
  logic [DATA_WIDTH-1:0]    pix_q [0:24];
  logic [DATA_WIDTH-1:0]    ker_q [0:24];

  logic [4:0]               idx;
  logic [2:0]               last;
  logic signed [16:0]       prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic [RESULT_WIDTH-1:0]  res_next;
  logic                     wr_ok;

  // Window edge is N-1 = size+1; only the top-left NxN entries are ever addressed.
  assign last     = {1'b0, size_q} + 3'd1;
  assign idx      = {2'b00, row_q} * 5'd5 + {2'b00, col_q};
  assign prod     = $signed({1'b0, pix_q[idx]}) * $signed(ker_q[idx]);
  assign acc_next = acc_q + ACC_W'(prod);

`ifdef CONV_SATURATE_EN
  always_comb begin
    res_next = acc_next[RESULT_WIDTH-1:0];
    if (acc_next > 21'sd32767) begin
      res_next = 16'h7FFF;
    end else if (acc_next < -21'sd32768) begin
      res_next = 16'h8000;
    end
  end
`else
  assign res_next = acc_next[RESULT_WIDTH-1:0];
`endif

  assign wr_ok    = wr_en && (state_q != S_RUN) && (wr_addr <= 5'd24);
  assign wr_err_d = wr_en && !wr_ok;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          size_d  = matrix_size;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_next;
        if (col_q == last) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
        if ((row_q == last) && (col_q == last)) begin
          state_d = S_DONE;
          res_d   = res_next;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 25; i++) begin
        pix_q[i] <= '0;
        ker_q[i] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        ker_q[wr_addr] <= wr_data;
      end else begin
        pix_q[wr_addr] <= wr_data;
      end
    end
  end

  assign wr_err       = wr_err_q;
  assign busy         = (state_q == S_RUN);
  assign result_valid = valid_q;
  assign result_out   = {{(200-RESULT_WIDTH){1'b0}}, res_q};

endmodule

`default_nettype wire

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer.
`default_nettype none

module tb_conv_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   matrix_size;
  logic         start;
  logic         wr_en;
  logic         wr_sel;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_err;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [199:0] result_out;

  int total = 0;
  int bad   = 0;

  conv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .matrix_size  (matrix_size),
    .start        (start),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_out   (result_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 5'(addr);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic fill(input logic sel, input logic [7:0] d);
    for (int i = 0; i < 25; i++) wr(sel, i, d);
  endtask

  // Pulse start, then wait (bounded) for result_valid; checks latency, busy length and value.
  task automatic run(input string tag, input logic [1:0] sz, input logic [15:0] exp);
    int n;
    int cyc;
    int bcnt;
    n = int'(sz) + 2;
    matrix_size = sz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!result_valid && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 200'(cyc), 200'(n * n));
    chk({tag, " busy_len"}, 200'(bcnt), 200'(n * n));
    chk({tag, " busy_done"}, 200'(busy), 200'(0));
    chk({tag, " result"}, result_out, {184'b0, exp});
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, " valid_clr"}, 200'(result_valid), 200'(0));
    chk({tag, " idle"}, 200'(busy), 200'(0));
  endtask

  initial begin
    reset = 1'b1; matrix_size = 2'b00; start = 1'b0; wr_en = 1'b0;
    wr_sel = 1'b0; wr_addr = '0; wr_data = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst valid", 200'(result_valid), 200'(0));
    chk("rst busy", 200'(busy), 200'(0));
    chk("rst wr_err", 200'(wr_err), 200'(0));
    chk("rst result", result_out, 200'(0));

    // 1: 2x2 of 255 * -128 -> -130560
    fill(1'b0, 8'hFF);
    fill(1'b1, 8'h80);
`ifdef CONV_SATURATE_EN
    run("t1", 2'b00, 16'h8000);
`else
    run("t1", 2'b00, 16'h0200);
`endif
    accept("t1");

    // 2: 3x3 window of 1..9 against kernel 1, surroundings poisoned
    fill(1'b0, 8'hFF);
    fill(1'b1, 8'hFF);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        wr(1'b0, r * 5 + c, 8'(r * 3 + c + 1));
        wr(1'b1, r * 5 + c, 8'h01);
      end
    end
    run("t2", 2'b01, 16'h002D);
    accept("t2");

    // 3: 5x5 of 10 * 1 = 250
    fill(1'b0, 8'd10);
    fill(1'b1, 8'd1);
    run("t3", 2'b11, 16'h00FA);

    // 4: backpressure with an ignored start
    for (int i = 0; i < 10; i++) begin
      matrix_size = 2'b00;
      start = (i == 3);
      @(negedge clk);
      chk("t4 hold_valid", 200'(result_valid), 200'(1));
      chk("t4 hold_result", result_out, {184'b0, 16'h00FA});
    end
    start = 1'b0;
    accept("t4");
    @(negedge clk);
    chk("t4 no_queue", 200'(busy), 200'(0));

    // 5: write during RUN and out-of-range write are both dropped
    matrix_size = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wr(1'b0, 0, 8'h55);
    chk("t5 err_run", 200'(wr_err), 200'(1));
    @(negedge clk);
    chk("t5 err_run_end", 200'(wr_err), 200'(0));
    for (int i = 0; i < 40 && !result_valid; i++) @(negedge clk);
    chk("t5 run_result", result_out, {184'b0, 16'h00FA});
    accept("t5");
    wr(1'b0, 25, 8'h55);
    chk("t5 err_addr", 200'(wr_err), 200'(1));
    @(negedge clk);
    chk("t5 err_addr_end", 200'(wr_err), 200'(0));
    run("t5 rerun", 2'b11, 16'h00FA);
    accept("t5 rerun");

    // 6: reset mid-run aborts and clears buffers
    matrix_size = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6 busy", 200'(busy), 200'(0));
    chk("t6 valid", 200'(result_valid), 200'(0));
    chk("t6 result", result_out, 200'(0));
    fill(1'b1, 8'd1);
    run("t6 pix_clr", 2'b11, 16'h0000);
    accept("t6 pix_clr");
    fill(1'b0, 8'd2);
    run("t6 fresh", 2'b01, 16'h0012);
    accept("t6 fresh");

    // 7: unsigned pixel, negative kernel; last pixel written on the start edge
    fill(1'b0, 8'd0);
    fill(1'b1, 8'hFF);
    wr(1'b0, 0, 8'd200);
    wr(1'b0, 1, 8'd200);
    wr(1'b0, 5, 8'd200);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd6; wr_data = 8'd200;
    run("t7", 2'b00, 16'hFCE0);
    accept("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Sequential convolution engine for the coprocessor: holds a 5x5 pixel buffer and a 5x5 kernel buffer, both loaded byte-wise over a write port. On start it walks the active NxN window (N = 2..5), one multiply-accumulate per clock, then presents the 16-bit result through a valid/ready handshake. It sits between the coprocessor instruction decoder and the result bus, and replaces a flat 200-bit combinational path with a one-MAC serial schedule.

Parameters:
DATA_WIDTH, 8, pixel/kernel element width. Fixed; informational only.
RESULT_WIDTH, 16, accumulated result width carried in the low bits of result_out.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
matrix_size  input  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; latched at start
start  input  1  request a convolution; sampled only in IDLE
wr_en  input  1  buffer write strobe
wr_sel  input  1  0 = pixel buffer, 1 = kernel buffer
wr_addr  input  5  linear index, row*5+col, 0..24
wr_data  input  8  pixel (unsigned) or kernel coefficient (signed)
wr_err  output  1  one-cycle pulse on a rejected write
busy  output  1  high while in RUN
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
result_out  output  200  {184'b0, result[15:0]}

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state=IDLE; pixel and kernel buffers all 0; accumulator 0; row/col counters 0; result_out=0; result_valid=0; busy=0; wr_err=0. A reset during RUN or DONE aborts the operation; no result is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start=1. On that edge: latch matrix_size as N; clear the accumulator; set row=col=0. busy rises after that edge.
- RUN, every edge:
  - idx = row*5+col
  - acc += $signed({1'b0,pixel[idx]}) * $signed(kernel[idx])
  - col increments; when col reaches N-1 it wraps to 0 and row increments.
  - On the edge that processes (N-1,N-1): go to DONE, result_out <= {184'b0, acc_next[15:0]}, result_valid <= 1.
- Latency: result_valid rises exactly N² edges after the start edge (4, 9, 16 or 25).
- Only the NxN top-left window contributes. Buffer entries outside it are never read.
- Arithmetic:
  - Each product is a 9-bit signed pixel times an 8-bit signed kernel value.
  - The accumulator is 16-bit two's complement and wraps on overflow (default build).
- DONE: result_valid and result_out stay stable until result_ready=1. On the edge with result_valid&&result_ready: go to IDLE and clear result_valid. result_out keeps its last value.
- start is ignored in RUN and DONE. It is not queued.
- Writes:
  - Accepted in IDLE and DONE when wr_addr<=24. They take effect on the same edge.
  - wr_en in RUN, or with wr_addr>24: the write is dropped and wr_err pulses for one cycle. Buffers are unchanged.
- start and wr_en on the same IDLE edge: the write is committed, and the first MAC (next edge) sees the new value.
- busy = (state==RUN).

Optional Feature:
CONV_SATURATE_EN
- Defined:
  - The accumulator is widened to 21 bits signed. This is enough for 25 * 255 * ±128.
  - At DONE the value is clamped to [-32768, 32767] before being written to result_out[15:0].
  - Latency is unchanged.
- Undefined: 16-bit wrap-around accumulation as described in Behaviour.

Test Plan:
1. 2x2, all pixels 0xFF, all kernel 0x80 (-128), start -> result_valid 4 cycles later.
   - Default build: result_out[15:0]=0x0200 (-130560 wrapped).
   - With CONV_SATURATE_EN: 0x8000.
2. 3x3 with pixels 1..9 at idx row*5+col, kernel 0x01 in the 3x3 window and 0xFF elsewhere; pixels outside the window = 0xFF -> result 0x002D after 9 cycles; upper 184 bits 0.
3. 5x5, all pixels 10, all kernel 1 -> result 0x00FA after exactly 25 cycles; busy high for exactly 25 cycles.
4. Backpressure: hold result_ready=0 for 10 cycles after valid and pulse start during that time -> result_valid and result_out are held and start is ignored. Raise result_ready -> IDLE next edge with result_valid=0.
5. Write during RUN (wr_sel=0, wr_addr=0, wr_data=0x55), then a write with wr_addr=25 in IDLE -> wr_err pulses once for each write. Both writes are dropped, and rerunning the same start gives an unchanged result.
6. Assert reset on cycle 10 of a 5x5 run -> next cycle busy=0, result_valid=0, result_out=0, buffers 0. A fresh load plus start then computes correctly.
